// File: rtl/packet_serializer.sv
// packet_serializer: FIFO-buffered parallel-to-serial converter, MSB first, one bit per clock
//   clock/reset           : rising-edge clock, synchronous active-high reset
//   io_pIn/io_validIn     : parallel packet input, accepted when io_readyIn is high
//   io_readyIn            : FIFO not full
//   io_sOut/io_sValid     : serial bit and its qualifier
//   io_sLast              : final bit of the current frame
//   SERIALIZER_PARITY_EN  : when defined, each frame carries a trailing even-parity bit
module packet_serializer #(
  parameter int PKT_W      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [PKT_W-1:0] io_pIn,
  input  logic             io_validIn,
  output logic             io_readyIn,
  output logic             io_sOut,
  output logic             io_sValid,
  output logic             io_sLast
);
`ifdef SERIALIZER_PARITY_EN
  localparam int FW = PKT_W + 1;
`else
  localparam int FW = PKT_W;
`endif
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(FW);
  typedef enum logic {S_IDLE, S_SHIFT} state_t;
  state_t            r_state, w_state_nxt;
  logic [PKT_W-1:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [FW-1:0]     r_shift, w_load;
  logic [BW-1:0]     r_bit;
  logic [PKT_W-1:0]  w_head;
  logic              w_push, w_pop, w_last, w_empty, w_full;
  assign w_full     = r_count == CW'(FIFO_DEPTH);
  assign w_empty    = r_count == '0;
  assign io_readyIn = !w_full;
  assign w_push     = io_validIn && !w_full;
  assign w_last     = r_state == S_SHIFT && r_bit == BW'(FW - 1);
  assign w_head     = r_mem[r_rd_ptr];
`ifdef SERIALIZER_PARITY_EN
  assign w_load = {w_head, ^w_head};
`else
  assign w_load = w_head;
`endif
  assign io_sValid = r_state == S_SHIFT;
  assign io_sOut   = io_sValid && r_shift[FW-1];
  assign io_sLast  = w_last;
  // Reloading on the last-bit edge keeps consecutive frames gap-free.
  always_comb begin
    w_pop       = !w_empty && (r_state == S_IDLE || w_last);
    w_state_nxt = w_pop ? S_SHIFT : (w_last ? S_IDLE : r_state);
  end
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= io_pIn;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_shift  <= '0;
      r_bit    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop) r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
      if (w_pop) begin
        r_shift <= w_load;
        r_bit   <= '0;
      end else if (r_state == S_SHIFT) begin
        r_shift <= r_shift << 1;
        r_bit   <= r_bit + BW'(1);
      end
    end
  end
endmodule

// File: tb/tb_packet_serializer.sv
// tb_packet_serializer: directed bench with a bit-queue reference model checked every cycle
module tb_packet_serializer;
  localparam int PKT_W = 4;
  localparam int D     = 4;
`ifdef SERIALIZER_PARITY_EN
  localparam int FW = PKT_W + 1;
  localparam int L_A_BITS = 'b10100, L_A_LAST = 'b00001;
  localparam int L_BB_BITS = 'b1010011110, L_BB_LAST = 'b0000100001;
  localparam int L_B_BITS = 'b10111, L_3_BITS = 'b00110;
`else
  localparam int FW = PKT_W;
  localparam int L_A_BITS = 'b1010, L_A_LAST = 'b0001;
  localparam int L_BB_BITS = 'b10101111, L_BB_LAST = 'b00010001;
  localparam int L_B_BITS = 'b1011, L_3_BITS = 'b0011;
`endif
  logic clock, reset, io_validIn, io_readyIn, io_sOut, io_sValid, io_sLast;
  logic [PKT_W-1:0] io_pIn;
  int n_cmp = 0, n_bad = 0;
  logic [PKT_W-1:0] fifo[$];
  logic frame[$];
  int rx[$];
  int acc_v = 0;
  bit armed = 0;
  packet_serializer #(.PKT_W(PKT_W), .FIFO_DEPTH(D)) dut (
    .clock(clock), .reset(reset), .io_pIn(io_pIn), .io_validIn(io_validIn),
    .io_readyIn(io_readyIn), .io_sOut(io_sOut), .io_sValid(io_sValid), .io_sLast(io_sLast)
  );
  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int frame_of(input logic [PKT_W-1:0] p);
    int r;
    r = int'(p);
`ifdef SERIALIZER_PARITY_EN
    r = (r << 1) | int'(^p);
`endif
    return r;
  endfunction
  always @(posedge clock) begin
    bit pop_ok, acc;
    logic [PKT_W-1:0] p;
    if (reset) begin
      fifo.delete();
      frame.delete();
      acc_v = 0;
      armed = 1;
    end else if (armed) begin
      pop_ok = frame.size() <= 1 && fifo.size() > 0;
      acc = io_validIn && fifo.size() < D;
      if (frame.size() > 0) void'(frame.pop_front());
      if (pop_ok) begin
        p = fifo.pop_front();
        for (int i = PKT_W - 1; i >= 0; i--) frame.push_back(p[i]);
`ifdef SERIALIZER_PARITY_EN
        frame.push_back(^p);
`endif
      end
      if (acc) fifo.push_back(io_pIn);
    end
  end
  always @(negedge clock) begin
    if (armed) begin
      chk("readyIn", io_readyIn, fifo.size() < D);
      chk("sValid", io_sValid, frame.size() > 0);
      chk("sOut", io_sOut, frame.size() > 0 ? frame[0] : 1'b0);
      chk("sLast", io_sLast, frame.size() == 1);
      if (io_sValid === 1'b1) begin
        acc_v = (acc_v << 1) | int'(io_sOut);
        if (io_sLast === 1'b1) begin
          rx.push_back(acc_v);
          acc_v = 0;
        end
      end
    end
  end
  task automatic send(input logic [PKT_W-1:0] p);
    io_pIn = p;
    io_validIn = 1;
    @(negedge clock);
    io_validIn = 0;
  endtask
  task automatic cap(input int n, input bit now, output int bits, output int lasts);
    bits = 0;
    lasts = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0 || !now) @(negedge clock);
      bits = (bits << 1) | int'(io_sOut);
      lasts = (lasts << 1) | int'(io_sLast);
    end
  endtask
  initial begin
    int b, l, idx, guard;
    bit a, saw_nr;
    logic [PKT_W-1:0] pk [6] = '{4'h3, 4'h5, 4'h9, 4'hC, 4'h6, 4'hE};
    reset = 1;
    io_validIn = 0;
    io_pIn = '0;
    @(negedge clock);
    reset = 0;
    chk("rst_readyIn", io_readyIn, 1);
    chk("rst_sValid", io_sValid, 0);
    chk("rst_sOut", io_sOut, 0);
    repeat (10) begin
      @(negedge clock);
      chk("idle_sValid", io_sValid, 0);
    end
    send(4'hA);
    cap(FW, 0, b, l);
    chk("single_bits", b, L_A_BITS);
    chk("single_last", l, L_A_LAST);
    @(negedge clock);
    chk("single_done", io_sValid, 0);
    repeat (3) @(negedge clock);
    io_pIn = 4'hA;
    io_validIn = 1;
    @(negedge clock);
    io_pIn = 4'hF;
    @(negedge clock);
    io_validIn = 0;
    cap(2 * FW, 1, b, l);
    chk("b2b_bits", b, L_BB_BITS);
    chk("b2b_last", l, L_BB_LAST);
    @(negedge clock);
    chk("b2b_done", io_sValid, 0);
    repeat (3) @(negedge clock);
    send(4'hB);
    cap(FW, 0, b, l);
    chk("pkt_B_bits", b, L_B_BITS);
    repeat (3) @(negedge clock);
    send(4'h3);
    cap(FW, 0, b, l);
    chk("pkt_3_bits", b, L_3_BITS);
    chk("pkt_3_final", b & 1, L_3_BITS & 1);
    repeat (3) @(negedge clock);
    rx.delete();
    idx = 0;
    guard = 0;
    saw_nr = 0;
    while (idx < 6 && guard < 200) begin
      io_pIn = pk[idx];
      io_validIn = 1;
      a = io_readyIn;
      if (!a) saw_nr = 1;
      @(negedge clock);
      if (a) idx++;
      guard++;
    end
    io_validIn = 0;
    chk("bp_sent", idx, 6);
    chk("bp_notready_seen", saw_nr, 1);
    guard = 0;
    while (rx.size() < 6 && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    chk("bp_rx_count", rx.size(), 6);
    for (int i = 0; i < 6; i++) chk("bp_order", i < rx.size() ? rx[i] : -1, frame_of(pk[i]));
    repeat (3) @(negedge clock);
    chk("bp_ready_back", io_readyIn, 1);
    send(4'hC);
    @(negedge clock);
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    reset = 0;
    chk("midrst_sValid", io_sValid, 0);
    chk("midrst_sOut", io_sOut, 0);
    repeat (8) begin
      @(negedge clock);
      chk("midrst_quiet", io_sValid, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/packet_serializer.md
Name: packet_serializer

Overview:
- Parallel-to-serial converter: accepts PKT_W-bit packets on a valid/ready interface, buffers them in a small FIFO and emits them MSB-first, one bit per clock, on a single serial line.
- Sits between a packet producer (e.g. the pixel/command pipeline) and a serial link driver.
- Everything runs in one clock domain; the serial bit rate equals the clock rate.

Parameters:
- PKT_W, 4, packet width in bits (>=2).
- FIFO_DEPTH, 4, number of buffered packets (power of two, >=2).

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- io_pIn  in  PKT_W  parallel packet.
- io_validIn  in  1  io_pIn holds a packet.
- io_readyIn  out  1  FIFO can accept a packet.
- io_sOut  out  1  serial data bit.
- io_sValid  out  1  io_sOut carries a packet bit.
- io_sLast  out  1  current bit is the final bit of its frame.

Behaviour:
- Reset (sampled on clock edge): FIFO emptied, shifter idle, bit counter 0. io_sOut=0, io_sValid=0, io_sLast=0 and io_readyIn=1 after the edge. Reset mid-frame aborts the frame with no further bits.
- Accept rules:
  - A packet is accepted on an edge where io_validIn && io_readyIn; io_pIn is written into the FIFO.
  - io_readyIn = !full, combinational from the registered FIFO count.
  - io_validIn while io_readyIn=0 is ignored; the producer must hold the packet.
- Shifter states:
  - IDLE: io_sValid=0, io_sOut=0. If the FIFO is non-empty, the next edge pops the head into the shift register and enters SHIFT.
  - SHIFT: io_sOut = shift register MSB (registered output), io_sValid=1. Each edge shifts left by one and increments the bit counter.
  - io_sLast=1 when bit counter = PKT_W-1 (frame length minus 1).
  - On the last-bit edge: if the FIFO is non-empty, pop and reload in the same edge, so frames are contiguous with no gap bit. Otherwise return to IDLE.
- Latency: a packet accepted at edge T into an empty FIFO with an idle shifter gives its MSB on io_sOut after edge T+1. Its LSB appears after edge T+PKT_W.
- Simultaneous push and pop: allowed in the same edge, count unchanged. A push when full is impossible because readyIn=0. A pop when empty does not occur.
- FIFO pointers wrap modulo FIFO_DEPTH. The count is FIFO_DEPTH+1 values wide to distinguish full from empty.
- Bit order: MSB first. Data is otherwise unmodified.

Optional Feature:
- Macro: SERIALIZER_PARITY_EN.
- Defined:
  - Each frame is PKT_W+1 bits: the data bits, then one even-parity bit (XOR of all PKT_W data bits).
  - io_sLast asserts on the parity bit; back-to-back reload happens after the parity bit.
  - Latency to the first bit is unchanged.
- Undefined: frames are exactly PKT_W bits and no parity logic is present.

Test Plan:
- Reset: hold reset 1 cycle, then idle 10 cycles -> io_sValid=0, io_sOut=0, io_readyIn=1 throughout.
- Single packet: pIn=0xA valid for 1 cycle at edge T -> after T+1..T+4, sOut=1,0,1,0 with sValid=1 and sLast only on the 4th bit. After T+5, sValid=0.
- Back-to-back: 0xA at edge T, 0xF at edge T+1 -> sOut=1,0,1,0,1,1,1,1 contiguous after edges T+1..T+8, sLast high on bits 4 and 8, no gap.
- Backpressure: push 6 packets with validIn held high, FIFO_DEPTH=4 -> readyIn drops once full and recovers as packets pop. All 6 packets emerge in order, none dropped or duplicated.
- Reset mid-frame: assert reset during bit 2 of 0xC -> after the reset edge sValid=0 and sOut=0, and no leftover bits are emitted once reset deasserts.
- Parity (SERIALIZER_PARITY_EN): pIn=0xB -> sOut=1,0,1,1,1 with sLast on the 5th bit. pIn=0x3 -> final bit 0.
